// File: rtl/reg_window_file.sv
// Windowed register file: 8 physical registers seen through a 4-register logical window
// that advances by two per window step. Optional REG_WINDOW_BYPASS_EN forwards same-cycle writes to reads.
module reg_window_file #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             reg_write,
   input  logic             ld_window,
   input  logic [1:0]       window_in,
   input  logic [1:0]       ri_addr,
   input  logic [1:0]       rj_addr,
   input  logic [1:0]       wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data_i,
   output logic [WIDTH-1:0] rd_data_j,
   output logic             rd_valid_i,
   output logic             rd_valid_j,
   output logic [1:0]       window_out
);

   logic [WIDTH-1:0] regs_q [8];
   logic [WIDTH-1:0] regs_d [8];
   logic [7:0]       valid_q;
   logic [7:0]       valid_d;
   logic [1:0]       wp_q;
   logic [1:0]       wp_d;

   logic [2:0]       ri_phys;
   logic [2:0]       rj_phys;
   logic [2:0]       wr_phys;
   logic [WIDTH-1:0] data_i;
   logic [WIDTH-1:0] data_j;
   logic             valid_i;
   logic             valid_j;

   // 3-bit sum wraps naturally, giving (2*wp + n) mod 8
   function automatic logic [2:0] map_phys(input logic [1:0] wp, input logic [1:0] n);
      map_phys = {wp, 1'b0} + {1'b0, n};
   endfunction

   assign ri_phys = map_phys(wp_q, ri_addr);
   assign rj_phys = map_phys(wp_q, rj_addr);
   assign wr_phys = map_phys(wp_q, wr_addr);

   // Next-state: writes use the current (old) window even when the window loads in the same cycle
   always_comb begin
      regs_d  = regs_q;
      valid_d = valid_q;
      wp_d    = wp_q;
      if (reg_write) begin
         regs_d[wr_phys]  = wr_data;
         valid_d[wr_phys] = 1'b1;
      end else begin
         valid_d = valid_q;
      end
      if (ld_window) begin
         wp_d = window_in;
      end else begin
         wp_d = wp_q;
      end
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 8; k++) begin
            regs_q[k] <= '0;
         end
         valid_q <= 8'h00;
         wp_q    <= 2'd0;
      end else begin
         regs_q  <= regs_d;
         valid_q <= valid_d;
         wp_q    <= wp_d;
      end
   end

   // Read muxes, with optional same-cycle write forwarding
   always_comb begin
      data_i  = regs_q[ri_phys];
      data_j  = regs_q[rj_phys];
      valid_i = valid_q[ri_phys];
      valid_j = valid_q[rj_phys];
`ifdef REG_WINDOW_BYPASS_EN
      if (reg_write && (wr_phys == ri_phys)) begin
         data_i  = wr_data;
         valid_i = 1'b1;
      end else begin
         data_i  = regs_q[ri_phys];
         valid_i = valid_q[ri_phys];
      end
      if (reg_write && (wr_phys == rj_phys)) begin
         data_j  = wr_data;
         valid_j = 1'b1;
      end else begin
         data_j  = regs_q[rj_phys];
         valid_j = valid_q[rj_phys];
      end
`else
      data_i  = regs_q[ri_phys];
      data_j  = regs_q[rj_phys];
      valid_i = valid_q[ri_phys];
      valid_j = valid_q[rj_phys];
`endif
   end

   // Reset masks the outputs so forwarded write data cannot leak out while rst is high
   always_comb begin
      if (rst) begin
         rd_data_i  = '0;
         rd_data_j  = '0;
         rd_valid_i = 1'b0;
         rd_valid_j = 1'b0;
         window_out = 2'd0;
      end else begin
         rd_data_i  = data_i;
         rd_data_j  = data_j;
         rd_valid_i = valid_i;
         rd_valid_j = valid_j;
         window_out = wp_q;
      end
   end

endmodule

// File: doc/reg_window_file.md
REG_WINDOW_FILE -- requirements
Module: reg_window_file

Interface
REQ-001 SHALL have parameter: WIDTH, 16, data word width in bits.
REQ-002 SHALL have port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: reg_write  input  1  write enable from control unit.
REQ-005 SHALL have port: ld_window  input  1  window-pointer load enable from control unit.
REQ-006 SHALL have port: window_in  input  2  new window number, valid when ld_window=1.
REQ-007 SHALL have port: ri_addr  input  2  logical read address, port I.
REQ-008 SHALL have port: rj_addr  input  2  logical read address, port J.
REQ-009 SHALL have port: wr_addr  input  2  logical write address.
REQ-010 SHALL have port: wr_data  input  WIDTH  write data (ALU or memory result).
REQ-011 SHALL have port: rd_data_i  output  WIDTH  port I read data.
REQ-012 SHALL have port: rd_data_j  output  WIDTH  port J read data.
REQ-013 SHALL have port: rd_valid_i  output  1  port I physical register written since reset.
REQ-014 SHALL have port: rd_valid_j  output  1  port J physical register written since reset.
REQ-015 SHALL have port: window_out  output  2  current window pointer.

Function
REQ-016 SHALL hold 8 physical registers P0..P7 of WIDTH bits, one valid bit each, and a 2-bit window pointer wp.
REQ-017 SHALL map logical index n to physical index (2*wp + n) mod 8; adjacent windows overlap by two registers.
REQ-018 SHALL wrap around: wp=3, n=2 maps to P0; wp=3, n=3 maps to P1.
REQ-019 SHALL read both ports combinationally (zero latency) through the mapping using the current wp.
REQ-020 SHALL, on a clock edge with reg_write=1, write wr_data to the mapped physical register and set its valid bit.
REQ-021 SHALL, on a clock edge with ld_window=1, load wp with window_in; new window visible to reads from the following cycle.
REQ-022 SHALL, when reg_write and ld_window are both 1 in one cycle, perform the write through the old wp.
REQ-023 SHALL permit ri_addr, rj_addr and wr_addr to be equal; both read ports return identical data when addresses map to the same register.
REQ-024 SHALL leave registers, valid bits and wp unchanged in cycles with both enables low.
REQ-025 SHALL drive window_out equal to wp at all times.

Reset
REQ-026 SHALL, on rst assertion, immediately clear all P0..P7 to 0, all valid bits to 0, and wp to 0, independent of clk.
REQ-027 SHALL, while rst is high, ignore reg_write and ld_window; rd_data_i/j read 0, rd_valid_i/j read 0, window_out reads 0.
REQ-028 SHALL abort any write or window load coinciding with reset assertion; first update occurs on the first rising edge after rst deasserts.

Configuration
REQ-029 SHALL support macro REG_WINDOW_BYPASS_EN.
REQ-030 SHALL, with REG_WINDOW_BYPASS_EN defined, forward wr_data (and valid=1) to a read port when reg_write=1 and that port maps to the same physical register as the write in the same cycle.
REQ-031 SHALL, without REG_WINDOW_BYPASS_EN, return the stored pre-write value on a same-cycle read/write collision.

Verification
REQ-032 SHALL test: reset, wp=0, write 0x1234 to logical 1 -> P1=0x1234, rd_data_i=0x1234 with ri_addr=1, rd_valid_i=1, rd_valid_j=0 for unwritten rj_addr=2.
REQ-033 SHALL test: write 0xAAAA to logical 2 at wp=0, load window_in=1 -> next cycle ri_addr=0 returns 0xAAAA (overlap P2).
REQ-034 SHALL test: wp=3, write 0x00F0 to logical 2 -> P0=0x00F0; load window_in=0, ri_addr=0 returns 0x00F0 (wrap-around).
REQ-035 SHALL test: same cycle reg_write=1 wr_addr=0 wr_data=0x5555 and ld_window=1 window_in=2 at wp=0 -> P0=0x5555, P4 unchanged, window_out=2 next cycle.
REQ-036 SHALL test: write 0x7777 with ri_addr=wr_addr=3 -> rd_data_i=0x7777 same cycle with REG_WINDOW_BYPASS_EN, old value without.
REQ-037 SHALL test: assert rst asynchronously mid-cycle after writes and wp=2 -> all outputs 0 before next clk edge; write on first post-reset edge succeeds.
